// File: rtl/rx_seq_if.sv
// Handshake bundle between the UART RX sequencer, the start-bit detector,
// the synchronized serial line and the shift register / RX buffer.
interface rx_seq_if;
   logic start_bit_detected;
   logic sync_serial;
   logic shift_strobe;
   logic load_buffer;
   logic framing_error;
   logic busy;

   // The environment (detector, line, datapath) drives the inputs and observes the controls.
   modport master (
      output start_bit_detected,
      output sync_serial,
      input  shift_strobe,
      input  load_buffer,
      input  framing_error,
      input  busy
   );

   modport slave (
      input  start_bit_detected,
      input  sync_serial,
      output shift_strobe,
      output load_buffer,
      output framing_error,
      output busy
   );
endinterface

// File: rtl/rx_frame_sequencer.sv
// UART RX control sequencer: times a frame from the start-bit pulse, strobes the
// shift register at each data-bit centre and loads the RX buffer or flags a framing error.
module rx_frame_sequencer #(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8
) (
   input logic    clk,
   input logic    n_rst,
   rx_seq_if.slave bus
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int BW   = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] PERIOD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST   = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam logic [BW-1:0] BITS_LAST   = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] BIT_ONE     = BW'(1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] bit_q, bit_d;
   logic          ferr_q, ferr_d;
   logic          strobe, load;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         ferr_q  <= ferr_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q == PERIOD_LAST) ? '0 : cnt_q + CNT_ONE;
      bit_d   = bit_q;
      ferr_d  = ferr_q;
      strobe  = 1'b0;
      load    = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.start_bit_detected) begin
               state_d = START;
               bit_d   = '0;
               ferr_d  = 1'b0;
            end
         end
         START: begin
            // Mid-start-bit check: a line already back high was a glitch, not a frame.
            if (cnt_q == HALF_LAST) begin
               state_d = bus.sync_serial ? IDLE : DATA;
               cnt_d   = '0;
            end
         end
         DATA: begin
            if (cnt_q == PERIOD_LAST) begin
               strobe = 1'b1;
               bit_d  = bit_q + BIT_ONE;
               if (bit_q == BITS_LAST) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (cnt_q == PERIOD_LAST) begin
               state_d = IDLE;
               if (bus.sync_serial) begin
                  load = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.shift_strobe  = strobe;
   assign bus.load_buffer   = load;
   assign bus.framing_error = ferr_q;
   assign bus.busy          = (state_q != IDLE);

endmodule
